// File: rtl/cgol_if.sv
// Bus between the Game of Life engine and its controller/display driver.
// o_gen_valid is a one-cycle strobe with no ready: the consumer samples o_board in that cycle.
interface cgol_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 16
);
  logic                       i_load;
  logic [ROWS*COLS-1:0]       i_seed;
  logic                       i_run;
  logic                       i_step;
  logic                       i_wrap;
  logic [ROWS*COLS-1:0]       o_board;
  logic                       o_gen_valid;
  logic [CNT_W-1:0]           o_gen_count;
  logic                       o_busy;
  logic                       o_stable;
  logic                       o_extinct;
  logic [1:0]                 dbg_state;
  logic [$clog2(ROWS)-1:0]    dbg_row;

  modport master (
    output i_load, i_seed, i_run, i_step, i_wrap,
    input  o_board, o_gen_valid, o_gen_count, o_busy, o_stable, o_extinct,
    input  dbg_state, dbg_row
  );

  modport slave (
    input  i_load, i_seed, i_run, i_step, i_wrap,
    output o_board, o_gen_valid, o_gen_count, o_busy, o_stable, o_extinct,
    output dbg_state, dbg_row
  );
endinterface

// File: rtl/cgol_engine.sv
// Conway's Game of Life engine: one row per cycle into a shadow buffer, committed atomically.
// Runs free (one generation per period) or single-steps; i_load overrides everything.
module cgol_engine #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int GEN_PERIOD     = 12000000,
  parameter int STOP_ON_STABLE = 0,
  parameter int CNT_W          = 16
) (
  input  logic   clk,
  input  logic   rst,
  cgol_if.slave  bus
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int TW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, COMPUTE = 2'd2, COMMIT = 2'd3} state_t;

  state_t           state;
  logic [N-1:0]     board;
  logic [N-1:0]     shadow;
  logic [RW-1:0]    row;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] gen_count;
  logic             gen_valid;
  logic             stable;
  logic             wrap_q;
  logic             halted;

  logic [COLS-1:0]  next_row;
  logic [3:0]       cnt;
  int               rr;
  int               cc;
  logic             ok;
  logic             same;

  // Next state of the current row, read only from the committed board.
  always_comb begin
    next_row = '0;
    cnt      = '0;
    rr       = 0;
    cc       = 0;
    ok       = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      cnt = '0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (!(dr == 0 && dc == 0)) begin
            ok = 1'b1;
            rr = int'(row) + dr;
            cc = c + dc;
            if (rr < 0) begin
              rr = ROWS - 1;
              ok = wrap_q;
            end else if (rr >= ROWS) begin
              rr = 0;
              ok = wrap_q;
            end
            if (cc < 0) begin
              cc = COLS - 1;
              ok = ok & wrap_q;
            end else if (cc >= COLS) begin
              cc = 0;
              ok = ok & wrap_q;
            end
            if (ok) cnt = cnt + 4'(board[rr*COLS + cc]);
          end
        end
      end
      if (board[int'(row)*COLS + c]) next_row[c] = (cnt == 4'd2) || (cnt == 4'd3);
      else                           next_row[c] = (cnt == 4'd3);
    end
  end

  assign same = (shadow == board);

  // halted keeps a stable-stopped run in IDLE until i_run is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      board     <= '0;
      shadow    <= '0;
      row       <= '0;
      timer     <= '0;
      gen_count <= '0;
      gen_valid <= 1'b0;
      stable    <= 1'b0;
      wrap_q    <= 1'b1;
      halted    <= 1'b0;
    end else begin
      gen_valid <= 1'b0;
      if (!bus.i_run) halted <= 1'b0;
      if (bus.i_load) begin
        board     <= bus.i_seed;
        gen_count <= '0;
        stable    <= 1'b0;
        state     <= IDLE;
        row       <= '0;
        gen_valid <= 1'b1;
        halted    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_step) begin
              state  <= COMPUTE;
              wrap_q <= bus.i_wrap;
              row    <= '0;
            end else if (bus.i_run && !halted) begin
              state <= WAIT;
              timer <= TW'(GEN_PERIOD - 1);
            end
          end
          WAIT: begin
            if (!bus.i_run) begin
              state <= IDLE;
            end else if (timer == '0) begin
              state  <= COMPUTE;
              wrap_q <= bus.i_wrap;
              row    <= '0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          COMPUTE: begin
            shadow[int'(row)*COLS +: COLS] <= next_row;
            if (row == RW'(ROWS - 1)) state <= COMMIT;
            else                      row   <= row + RW'(1);
          end
          COMMIT: begin
            board     <= shadow;
            gen_count <= gen_count + CNT_W'(1);
            stable    <= same;
            gen_valid <= 1'b1;
            row       <= '0;
            if (bus.i_run && !((STOP_ON_STABLE != 0) && same)) begin
              state <= WAIT;
              timer <= TW'(GEN_PERIOD - 1);
            end else begin
              state  <= IDLE;
              halted <= bus.i_run;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_board     = board;
  assign bus.o_gen_valid = gen_valid;
  assign bus.o_gen_count = gen_count;
  assign bus.o_busy      = (state == COMPUTE) || (state == COMMIT);
  assign bus.o_stable    = stable;
  assign bus.o_extinct   = ~|board;
  assign bus.dbg_state   = state;
  assign bus.dbg_row     = row;
endmodule

// File: tb/tb_cgol_engine.sv
// Bench for cgol_engine: directed scenarios plus random seeds, scoreboard fed by a board-level Life model.
module tb_cgol_engine;
  localparam int R = 8;
  localparam int C = 8;
  localparam int N = R * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cgol_if #(.ROWS(R), .COLS(C), .CNT_W(16)) ifa ();
  cgol_if #(.ROWS(R), .COLS(C), .CNT_W(16)) ifb ();

  cgol_engine #(.ROWS(R), .COLS(C), .GEN_PERIOD(4), .STOP_ON_STABLE(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  cgol_engine #(.ROWS(R), .COLS(C), .GEN_PERIOD(4), .STOP_ON_STABLE(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [79:0] exp_q[$];
  logic [N-1:0] mboard;
  int          mcount;
  bit          mstable;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-board generation from the Life rules on a 2-D view.
  function automatic logic [N-1:0] model_step(input logic [N-1:0] b, input bit wrap);
    logic [N-1:0] nb;
    int n, y, x;
    nb = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            y = r + dy;
            x = c + dx;
            if (wrap) begin
              y = (y + R) % R;
              x = (x + C) % C;
            end else if (y < 0 || y >= R || x < 0 || x >= C) begin
              continue;
            end
            n += int'(b[y*C + x]);
          end
        end
        nb[r*C + c] = b[r*C + c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nb;
  endfunction

  function automatic logic [79:0] pack(input int cnt, input logic [N-1:0] b);
    logic [15:0] c16;
    c16 = 16'(cnt);
    return {c16, b};
  endfunction

  // Monitor: every generation strobe on dut_a pops one expected {count, board}.
  always @(negedge clk) begin
    logic [79:0] e;
    if (!rst && ifa.o_gen_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got strobe with board %h, required no strobe", ifa.o_board);
      end else begin
        e = exp_q.pop_front();
        check("sb_board", ifa.o_board, e[63:0]);
        check("sb_count", 64'(ifa.o_gen_count), 64'(e[79:64]));
      end
    end
  end

  task automatic load_a(input logic [N-1:0] seed);
    @(negedge clk);
    ifa.i_load = 1'b1;
    ifa.i_seed = seed;
    mboard = seed;
    mcount = 0;
    exp_q.push_back(pack(0, seed));
    @(negedge clk);
    ifa.i_load = 1'b0;
  endtask

  task automatic step_a(input bit wrap, output int lat, output int busy_cyc);
    logic [N-1:0] prev;
    prev = mboard;
    mboard = model_step(mboard, wrap);
    mstable = (mboard == prev);
    mcount++;
    exp_q.push_back(pack(mcount, mboard));
    @(negedge clk);
    ifa.i_wrap = wrap;
    ifa.i_step = 1'b1;
    lat = -1;
    busy_cyc = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      ifa.i_step = 1'b0;
      if (ifa.o_busy) busy_cyc++;
      if (ifa.o_gen_valid) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy, pulses, t0, t1, t2, k, steps;
    bit w;
    logic [N-1:0] seed;
    ifa.i_load = 0; ifa.i_seed = '0; ifa.i_run = 0; ifa.i_step = 0; ifa.i_wrap = 1;
    ifb.i_load = 0; ifb.i_seed = '0; ifb.i_run = 0; ifb.i_step = 0; ifb.i_wrap = 1;

    // Reset values
    #2;
    check("rst_board", ifa.o_board, 64'h0);
    check("rst_count", 64'(ifa.o_gen_count), 64'h0);
    check("rst_valid", 64'(ifa.o_gen_valid), 64'h0);
    check("rst_stable", 64'(ifa.o_stable), 64'h0);
    check("rst_busy", 64'(ifa.o_busy), 64'h0);
    check("rst_extinct", 64'(ifa.o_extinct), 64'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Blinker, single steps with wrap
    load_a(64'h0000_0000_1C00_0000);
    step_a(1'b1, lat, busy);
    check("blink1_latency", 64'(lat), 64'd9);
    check("blink1_busy", 64'(busy), 64'd9);
    check("blink1_board", ifa.o_board, 64'h0000_0008_0808_0000);
    step_a(1'b1, lat, busy);
    check("blink2_board", ifa.o_board, 64'h0000_0000_1C00_0000);
    check("blink2_count", 64'(ifa.o_gen_count), 64'd2);
    check("blink2_stable", 64'(ifa.o_stable), 64'd0);

    // Boundary modes on a corner-straddling triple
    load_a(64'h83);
    step_a(1'b1, lat, busy);
    check("wrap1_board", ifa.o_board, 64'h0100_0000_0000_0101);
    load_a(64'h83);
    step_a(1'b0, lat, busy);
    check("wrap0_board", ifa.o_board, 64'h0);
    check("wrap0_extinct", 64'(ifa.o_extinct), 64'h1);

    // Free run: blinker, strobes 13 cycles apart, stop in WAIT
    load_a(64'h0000_0000_1C00_0000);
    for (int g = 0; g < 3; g++) begin
      mboard = model_step(mboard, 1'b1);
      mcount++;
      exp_q.push_back(pack(mcount, mboard));
    end
    @(negedge clk);
    ifa.i_wrap = 1'b1;
    ifa.i_run = 1'b1;
    k = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int n = 1; n <= 200 && k < 3; n++) begin
      @(negedge clk);
      if (ifa.o_gen_valid) begin
        if (k == 0) t0 = n; else if (k == 1) t1 = n; else t2 = n;
        k++;
      end
    end
    check("run_pulses", 64'(k), 64'd3);
    check("run_state_wait", 64'(ifa.dbg_state), 64'd1);
    ifa.i_run = 1'b0;
    check("run_spacing1", 64'(t1 - t0), 64'd13);
    check("run_spacing2", 64'(t2 - t1), 64'd13);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ifa.o_gen_valid) pulses++;
    end
    check("run_stop_quiet", 64'(pulses), 64'd0);
    check("run_stop_idle", 64'(ifa.dbg_state), 64'd0);

    // Stop-on-stable: block under i_run gives exactly one generation
    @(negedge clk);
    ifb.i_load = 1'b1;
    ifb.i_seed = 64'h303;
    @(negedge clk);
    ifb.i_load = 1'b0;
    ifb.i_run = 1'b1;
    check("sos_load_pulse", 64'(ifb.o_gen_valid), 64'd1);
    pulses = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (ifb.o_gen_valid) pulses++;
    end
    check("sos_pulses", 64'(pulses), 64'd1);
    check("sos_stable", 64'(ifb.o_stable), 64'd1);
    check("sos_count", 64'(ifb.o_gen_count), 64'd1);
    check("sos_idle", 64'(ifb.dbg_state), 64'd0);
    check("sos_board", ifb.o_board, 64'h303);
    ifb.i_run = 1'b0;

    // Load while COMPUTE is on row 4 discards the in-flight generation
    load_a(64'h0000_0000_1C00_0000);
    @(negedge clk);
    ifa.i_step = 1'b1;
    k = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ifa.i_step = 1'b0;
      if (ifa.dbg_state == 2'd2 && ifa.dbg_row == 3'd4) begin
        k = 1;
        break;
      end
    end
    check("midload_reached_row4", 64'(k), 64'd1);
    ifa.i_load = 1'b1;
    ifa.i_seed = 64'h303;
    mboard = 64'h303;
    mcount = 0;
    exp_q.push_back(pack(0, 64'h303));
    @(negedge clk);
    ifa.i_load = 1'b0;
    check("midload_board", ifa.o_board, 64'h303);
    check("midload_count", 64'(ifa.o_gen_count), 64'd0);
    check("midload_busy", 64'(ifa.o_busy), 64'd0);
    repeat (30) @(negedge clk);

    // Async reset in the middle of WAIT
    load_a(64'h0000_0000_1C00_0000);
    @(negedge clk);
    ifa.i_run = 1'b1;
    k = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifa.dbg_state == 2'd1) begin
        k = 1;
        break;
      end
    end
    check("arst_reached_wait", 64'(k), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_board", ifa.o_board, 64'h0);
    check("arst_count", 64'(ifa.o_gen_count), 64'h0);
    check("arst_valid", 64'(ifa.o_gen_valid), 64'h0);
    check("arst_stable", 64'(ifa.o_stable), 64'h0);
    check("arst_busy", 64'(ifa.o_busy), 64'h0);
    exp_q.delete();
    ifa.i_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mboard = '0;
    mcount = 0;
    step_a(1'b1, lat, busy);
    check("zero_latency", 64'(lat), 64'd9);
    check("zero_stable", 64'(ifa.o_stable), 64'd1);
    check("zero_extinct", 64'(ifa.o_extinct), 64'd1);

    // Random seeds, random boundary mode, a few steps each
    for (int it = 0; it < 8; it++) begin
      seed = {$urandom(), $urandom()};
      w = 1'($urandom_range(0, 1));
      load_a(seed);
      steps = $urandom_range(1, 3);
      for (int s = 0; s < steps; s++) begin
        step_a(w, lat, busy);
        check("rnd_latency", 64'(lat), 64'd9);
        check("rnd_stable", 64'(ifa.o_stable), 64'(mstable));
        check("rnd_extinct", 64'(ifa.o_extinct), 64'(mboard == '0));
      end
    end

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cgol_engine.md
Name: cgol_engine

Overview:
Parametrised Conway's Game of Life engine for an ROWS x COLS board. It runs either free-running, advancing one generation per period, or one step at a time. The next generation is computed one row per cycle into a shadow buffer and committed atomically. It sits between seed memory and the LED-matrix driver: seed comes in, o_board feeds the WS2812B pixel sequencer, and o_gen_valid tells the driver to refresh.

Parameters:
ROWS, 8, board height (>=3)
COLS, 8, board width (>=3)
GEN_PERIOD, 12000000, clk cycles spent in WAIT between generations when running (>=1)
STOP_ON_STABLE, 0, 1 = a run halts automatically when a commit produces an unchanged board
CNT_W, 16, width of generation counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_load  in  1  load i_seed into board; highest priority
i_seed  in  ROWS*COLS  seed; cell (r,c) = bit r*COLS+c
i_run  in  1  level; free-run while high
i_step  in  1  pulse; compute exactly one generation (honoured only in IDLE)
i_wrap  in  1  1 = toroidal boundary, 0 = dead (zero) boundary; latched on entry to COMPUTE
o_board  out  ROWS*COLS  current generation, same bit mapping as i_seed
o_gen_valid  out  1  one-cycle pulse, high in the cycle o_board first shows a new generation
o_gen_count  out  CNT_W  generations since last load; wraps modulo 2^CNT_W
o_busy  out  1  high in COMPUTE and COMMIT
o_stable  out  1  last commit left the board unchanged
o_extinct  out  1  o_board is all zero (combinational from o_board)

Behaviour:
- Reset (async, any state): state=IDLE, o_board=0, shadow=0, o_gen_count=0, o_gen_valid=0, o_stable=0, row index=0, timer=0, latched wrap=1.
- States: IDLE, WAIT, COMPUTE, COMMIT.
- IDLE:
  - i_step=1 -> COMPUTE.
  - else i_run=1 -> WAIT, timer=GEN_PERIOD-1.
  - i_step takes precedence when both are high.
- WAIT:
  - i_run=0 -> IDLE.
  - timer==0 -> COMPUTE.
  - otherwise timer decrements.
  - i_step is ignored.
- COMPUTE:
  - Row index runs 0..ROWS-1; one row per cycle.
  - Each row's next state is written into the shadow buffer from the unmodified o_board.
  - After row ROWS-1 -> COMMIT.
  - i_wrap, i_run and i_step are not sampled here.
- Neighbour rules:
  - 8-neighbourhood.
  - wrap=1: indices taken modulo ROWS/COLS.
  - wrap=0: out-of-range neighbours count as dead.
  - Count width is 4 bits.
  - Live cell survives iff count is 2 or 3.
  - Dead cell is born iff count is 3.
- COMMIT (single cycle):
  - o_board<=shadow.
  - o_gen_count++.
  - o_stable<=(shadow==o_board).
  - o_gen_valid=1 in the following cycle.
- COMMIT exit:
  - i_run=1 and not (STOP_ON_STABLE and stable) -> WAIT, timer=GEN_PERIOD-1.
  - otherwise -> IDLE.
- Latency: i_step sampled at edge E0 -> o_board new value and o_gen_valid=1 after edge E(ROWS+1).
- Run period: GEN_PERIOD+ROWS+1 cycles between o_gen_valid pulses.
- i_load (any state, overrides everything in that cycle):
  - o_board<=i_seed, o_gen_count<=0, o_stable<=0.
  - state<=IDLE; row index=0; any in-progress generation is discarded.
  - o_gen_valid=1 in the following cycle, so the driver displays the seed.
- o_gen_valid is never high for two consecutive cycles, except a load directly following a commit.
- All-zero board: computes normally (stays zero). o_stable=1 after the first commit; o_extinct=1 throughout.

Test Plan:
- ROWS=COLS=8, wrap=1: load 64'h0000_0000_1C00_0000 (horizontal blinker), step -> o_board=64'h0000_0008_0808_0000 exactly 9 cycles after step edge, o_gen_count=1, o_busy high 9 cycles. Step again -> back to 64'h1C00_0000, count=2, o_stable=0.
- Boundary mode, load 64'h83:
  - wrap=1, step -> 64'h0100_0000_0000_0101.
  - reload, wrap=0, step -> 64'h0, o_extinct=1.
- STOP_ON_STABLE=1, GEN_PERIOD=4: load 64'h303 (2x2 block), hold i_run=1 -> exactly one o_gen_valid after load pulse, o_stable=1, o_gen_count=1, state returns to IDLE with i_run still high.
- GEN_PERIOD=4, STOP_ON_STABLE=0, blinker, i_run=1 for 40 cycles:
  - o_gen_valid pulses spaced exactly 13 cycles apart.
  - o_board alternates between the two blinker patterns.
  - Dropping i_run during WAIT -> IDLE, no further pulses.
- Load mid-COMPUTE (row index 4): assert i_load with 64'h303 -> next cycle o_board=64'h303, o_gen_count=0, o_busy=0, shadow results never appear.
- Async rst asserted mid-WAIT, not aligned to clk -> all outputs zero immediately. After release, i_step on a zero board -> o_gen_valid after 9 cycles, board stays 0.
